// File: rtl/store_ordering_gate.sv
// Store ordering gate: caps in-flight stores and serialises non-idempotent stores behind a one-entry output stage.
// Optional macro STORE_GATE_STALL_CNT_EN builds a saturating upstream stall-cycle counter.
package cva6_config_pkg;
  localparam int unsigned NrMaxRules = 4;

  typedef struct packed {
    int unsigned                 MaxOutstandingStores;
    bit                          NonIdemPotenceEn;
    int unsigned                 NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
  } cva6_cfg;

  localparam cva6_cfg CfgDefault = '{
    MaxOutstandingStores:  32'd7,
    NonIdemPotenceEn:      1'b1,
    NrNonIdempotentRules:  32'd1,
    NonIdempotentAddrBase: {64'h0, 64'h0, 64'h0, 64'h0000_0000_1000_0000},
    NonIdempotentLength:   {64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_1000}
  };
endpackage

module store_ordering_gate #(
  parameter cva6_config_pkg::cva6_cfg CVA6Cfg = cva6_config_pkg::CfgDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 st_valid_i,
  output logic                 st_ready_o,
  input  logic [63:0]          st_paddr_i,
  input  logic [63:0]          st_data_i,
  input  logic [7:0]           st_be_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [63:0]          mem_paddr_o,
  output logic [63:0]          mem_data_o,
  output logic [7:0]           mem_be_o,
  input  logic                 mem_ack_i,
  output logic [$clog2(CVA6Cfg.MaxOutstandingStores+1)-1:0] outstanding_o,
  output logic                 no_st_pending_o,
  output logic                 err_o,
  output logic [31:0]          stall_cnt_o
);
  localparam int CntW = $clog2(CVA6Cfg.MaxOutstandingStores + 1);
  localparam logic [CntW:0]   MaxC = (CntW + 1)'(CVA6Cfg.MaxOutstandingStores);
  localparam logic [CntW-1:0] OneC = CntW'(1);

  if (CVA6Cfg.MaxOutstandingStores == 0) begin : g_max_zero
    $error("store_ordering_gate: MaxOutstandingStores must be non-zero");
  end

  typedef enum logic [1:0] {S_PASS = 2'd0, S_DRAIN = 2'd1, S_WAIT_NI = 2'd2} state_e;

  state_e            r_state, w_state_nxt;
  logic              r_buf_valid;
  logic [63:0]       r_paddr, r_data;
  logic [7:0]        r_be;
  logic [CntW-1:0]   r_cnt;
  logic              r_err;
  logic [CntW:0]     w_inflight;
  logic              w_space, w_ni, w_ready, w_accept, w_inc, w_dec;

  // 65-bit sum so a rule ending at the top of the address space cannot wrap.
  function automatic logic is_non_idem(input logic [63:0] addr);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < cva6_config_pkg::NrMaxRules; i++) begin
      if ((i < CVA6Cfg.NrNonIdempotentRules) &&
          (addr >= CVA6Cfg.NonIdempotentAddrBase[i]) &&
          ({1'b0, addr} < ({1'b0, CVA6Cfg.NonIdempotentAddrBase[i]} +
                           {1'b0, CVA6Cfg.NonIdempotentLength[i]}))) begin
        hit = 1'b1;
      end
    end
    return CVA6Cfg.NonIdemPotenceEn && hit;
  endfunction

  assign w_inflight = {1'b0, r_cnt} + {{CntW{1'b0}}, r_buf_valid};
  assign w_space    = !r_buf_valid || mem_ready_i;
  assign w_ni       = is_non_idem(st_paddr_i);
  assign w_accept   = st_valid_i && w_ready;
  assign w_inc      = r_buf_valid && mem_ready_i;
  assign w_dec      = mem_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_PASS: begin
        if (st_valid_i && w_ni) begin
          if (w_inflight == '0) begin
            w_ready     = 1'b1;
            w_state_nxt = S_WAIT_NI;
          end else begin
            w_ready     = 1'b0;
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_ready = w_space && (w_inflight < MaxC);
        end
      end
      S_DRAIN: begin
        w_ready = (w_inflight == '0);
        if (st_valid_i && w_ready) begin
          w_state_nxt = S_WAIT_NI;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_WAIT_NI: begin
        if (!r_buf_valid && (r_cnt == '0)) begin
          w_state_nxt = S_PASS;
        end else begin
          w_state_nxt = S_WAIT_NI;
        end
      end
      default: begin
        w_state_nxt = S_PASS;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output stage holds its contents until the downstream handshake; refill may overlap it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf_valid <= 1'b0;
      r_paddr     <= 64'd0;
      r_data      <= 64'd0;
      r_be        <= 8'd0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
      r_paddr     <= st_paddr_i;
      r_data      <= st_data_i;
      r_be        <= st_be_i;
    end else if (mem_ready_i) begin
      r_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + OneC;
    end else if (!w_inc && w_dec) begin
      if (r_cnt == '0) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt - OneC;
      end
    end
  end

`ifdef STORE_GATE_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= 32'd0;
    end else if (st_valid_i && !w_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign st_ready_o      = w_ready;
  assign mem_valid_o     = r_buf_valid;
  assign mem_paddr_o     = r_paddr;
  assign mem_data_o      = r_data;
  assign mem_be_o        = r_be;
  assign outstanding_o   = r_cnt;
  assign no_st_pending_o = (w_inflight == '0);
  assign err_o           = r_err;
endmodule

// File: tb/tb_store_ordering_gate.sv
// Scoreboard bench for store_ordering_gate with the default configuration (Max=7, one NI rule at 0x1000_0000/0x1000).
module tb_store_ordering_gate;
  logic        clk, rst_n;
  logic        st_valid_i, st_ready_o, mem_valid_o, mem_ready_i, mem_ack_i;
  logic        no_st_pending_o, err_o;
  logic [63:0] st_paddr_i, st_data_i, mem_paddr_o, mem_data_o;
  logic [7:0]  st_be_i, mem_be_o;
  logic [2:0]  outstanding_o;
  logic [31:0] stall_cnt_o;

  typedef struct {
    logic [63:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef STORE_GATE_STALL_CNT_EN
  localparam logic [63:0] StallExp = 64'd10;
`else
  localparam logic [63:0] StallExp = 64'd0;
`endif

  store_ordering_gate dut (
    .clk_i(clk), .rst_ni(rst_n),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_paddr_i(st_paddr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_paddr_o(mem_paddr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .outstanding_o(outstanding_o),
    .no_st_pending_o(no_st_pending_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    st_valid_i = 1'b1;
    st_paddr_i = a;
    st_data_i  = d;
    st_be_i    = be;
  endtask

  task automatic idle();
    st_valid_i = 1'b0;
  endtask

  task automatic wait_accept(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (st_ready_o) done = 1'b1;
      tick();
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack_i = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0;
  endtask

  // Upstream acceptances push expectations; downstream handshakes pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_valid_i && st_ready_o) begin
        exp_q.push_back('{paddr: st_paddr_i, data: st_data_i, be: st_be_i});
      end
      if (mem_valid_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_paddr", mem_paddr_o, e.paddr);
          check("sb_data", mem_data_o, e.data);
          check("sb_be", {56'd0, mem_be_o}, {56'd0, e.be});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; st_valid_i = 1'b0; st_paddr_i = 64'd0; st_data_i = 64'd0;
    st_be_i = 8'd0; mem_ready_i = 1'b1; mem_ack_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    check("rst_outstanding", {61'd0, outstanding_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
    check("rst_paddr", mem_paddr_o, 64'd0);
    check("rst_data", mem_data_o, 64'd0);
    check("rst_be", {56'd0, mem_be_o}, 64'd0);
    check("rst_ready", {63'd0, st_ready_o}, 64'd1);
    check("rst_no_pending", {63'd0, no_st_pending_o}, 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Cap: seven stores go out, the eighth waits for an ack.
    for (int i = 0; i < 7; i++) begin
      drive(64'h8000_0000 + 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF ^ 8'(i));
      wait_accept(3);
    end
    drive(64'h8000_0038, 64'hA5A5_0000_0000_0007, 8'h0F);
    @(negedge clk);
    check("cap_ready_full", {63'd0, st_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    check("cap_outstanding", {61'd0, outstanding_o}, 64'd7);
    check("cap_ready_hold", {63'd0, st_ready_o}, 64'd0);
    tick();
    ack_n(1);
    @(negedge clk);
    check("cap_ready_after_ack", {63'd0, st_ready_o}, 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("cap_latency", {63'd0, mem_valid_o}, 64'd1);
    tick();
    ack_n(7);
    @(negedge clk);
    check("cap_drained", {61'd0, outstanding_o}, 64'd0);
    check("cap_no_pending", {63'd0, no_st_pending_o}, 64'd1);
    tick();

    // Non-idempotent store drains, issues alone, waits for its ack.
    for (int i = 0; i < 3; i++) begin
      drive(64'h8000_0080 + 64'(i * 8), 64'h1111_0000_0000_0000 | 64'(i), 8'h3C);
      wait_accept(3);
    end
    idle();
    tick();
    @(negedge clk);
    check("ni_pre_outstanding", {61'd0, outstanding_o}, 64'd3);
    tick();
    drive(64'h1000_0010, 64'hDEAD_BEEF_0000_0001, 8'hF0);
    @(negedge clk);
    check("ni_drain_ready0", {63'd0, st_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    check("ni_drain_ready1", {63'd0, st_ready_o}, 64'd0);
    tick();
    ack_n(3);
    @(negedge clk);
    check("ni_drain_done", {63'd0, st_ready_o}, 64'd1);
    tick();
    drive(64'h8000_0100, 64'h2222_0000_0000_0002, 8'h81);
    @(negedge clk);
    check("ni_issued", {63'd0, mem_valid_o}, 64'd1);
    check("ni_wait_ready0", {63'd0, st_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    check("ni_outstanding", {61'd0, outstanding_o}, 64'd1);
    check("ni_wait_ready1", {63'd0, st_ready_o}, 64'd0);
    tick();
    ack_n(1);
    @(negedge clk);
    check("ni_wait_after_ack", {63'd0, st_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    check("ni_pass_ready", {63'd0, st_ready_o}, 64'd1);
    tick();
    idle();
    tick();
    ack_n(1);
    @(negedge clk);
    check("ni_final_outstanding", {61'd0, outstanding_o}, 64'd0);
    tick();

    // Handshake and ack in the same cycle leave the counter unchanged.
    for (int i = 0; i < 4; i++) begin
      drive(64'h8000_0200 + 64'(i * 8), 64'h3333_0000_0000_0000 | 64'(i), 8'h55);
      wait_accept(3);
    end
    idle();
    tick();
    @(negedge clk);
    check("same_pre", {61'd0, outstanding_o}, 64'd4);
    tick();
    drive(64'h8000_0220, 64'h3333_0000_0000_0004, 8'hAA);
    wait_accept(3);
    idle();
    ack_n(1);
    @(negedge clk);
    check("same_cycle", {61'd0, outstanding_o}, 64'd4);
    tick();
    ack_n(4);

    // Spurious ack with an empty counter.
    ack_n(1);
    @(negedge clk);
    check("err_set", {63'd0, err_o}, 64'd1);
    check("err_outstanding", {61'd0, outstanding_o}, 64'd0);
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", {63'd0, err_o}, 64'd1);
    tick();

    // Asynchronous reset while holding a full buffer in WAIT_NI.
    mem_ready_i = 1'b0;
    drive(64'h1000_0020, 64'h4444_0000_0000_0000, 8'h01);
    wait_accept(3);
    idle();
    @(negedge clk);
    check("rst5_buf_full", {63'd0, mem_valid_o}, 64'd1);
    check("rst5_wait_ready", {63'd0, st_ready_o}, 64'd0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst5_mem_valid", {63'd0, mem_valid_o}, 64'd0);
    check("rst5_outstanding", {61'd0, outstanding_o}, 64'd0);
    check("rst5_err", {63'd0, err_o}, 64'd0);
    exp_q.delete();
    mem_ready_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst5_ready", {63'd0, st_ready_o}, 64'd1);
    check("rst5_no_pending", {63'd0, no_st_pending_o}, 64'd1);
    tick();

    // Ten stall cycles with the output stage blocked.
    mem_ready_i = 1'b0;
    drive(64'h8000_0300, 64'h5555_0000_0000_0000, 8'hC3);
    wait_accept(3);
    drive(64'h8000_0308, 64'h5555_0000_0000_0001, 8'h3C);
    repeat (10) tick();
    idle();
    @(negedge clk);
    check("stall_cnt", {32'd0, stall_cnt_o}, StallExp);
    tick();
    mem_ready_i = 1'b1;
    tick();
    ack_n(1);
    @(negedge clk);
    check("end_outstanding", {61'd0, outstanding_o}, 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("end_stall_cnt", {32'd0, stall_cnt_o}, StallExp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
